fsm_cnt_scheduler: RTL and testbench
====================================

# fsm_cnt_scheduler

Round-robin scheduler that shares one Moore counter FSM (2-bit mode `X`, enable `En`, count `Cuenta`) among four requesters. Each grant loads the winner's mode into the counter, runs it for a fixed number of enabled cycles, captures the resulting count and returns it with a done pulse. It sits between the requesting control logic and the counter instance and owns the counter's `X` and `En` inputs exclusively.

## Interface
- `NREQ`, 4: number of requesters (fixed at 4 for this revision).
- `BURST`, 4: enabled counter cycles per grant, legal range 1..255.
- `Clk  in  1`: single clock; all logic on rising edge.
- `Rst  in  1`: synchronous, active-high reset.
- `Req  in  4`: per-requester request level; held high until `Done` for that requester.
- `Mode  in  8`: packed modes, `Mode[2i+1:2i]` is requester i's X value.
- `Cuenta  in  2`: count from the shared counter FSM.
- `X  out  2`: mode driven to the counter.
- `En  out  1`: counter enable.
- `Gnt  out  4`: one-hot grant, zero when idle.
- `Done  out  1`: one-cycle pulse, result valid.
- `Abort  out  1`: qualifies `Done`; 1 = burst cut short by Req drop.
- `Result  out  2`: `Cuenta` captured at end of burst; holds until next `Done`.

## Operation
- States: IDLE, LOAD, RUN, FINISH.
- IDLE: `Gnt`=0, `En`=0. If any `Req` bit set, pick winner by round-robin (search starts at `last+1` mod 4, wraps), register `Gnt`, `X`←winner's mode, go LOAD.
- LOAD: one cycle, `Gnt` and `X` stable, `En`=0 (mode settles in counter). Go RUN, burst counter←`BURST`.
- RUN: `En`=1, burst counter decrements each cycle; at counter = 1 go FINISH normally. If the granted `Req` bit drops in RUN, `En` deasserts next cycle and go FINISH with abort flag set.
- FINISH: one cycle, `En`=0, `Result`←`Cuenta`, `Done`=1, `Abort`=abort flag, `last`←winner index. Go IDLE; `Gnt` clears on entry to IDLE.
- `X` changes only in IDLE→LOAD; never during LOAD/RUN/FINISH.
- Requests arriving while not IDLE wait; changes to `Mode` after grant are ignored.
- Reset values: state IDLE, `X`=0, `En`=0, `Gnt`=0, `Done`=0, `Abort`=0, `Result`=0, `last`=3 (requester 0 wins first), burst counter 0.
- Reset mid-burst: next edge all outputs at reset values; no `Done` pulse for the interrupted burst.

## Timing
- Request in IDLE at edge n → `Gnt`/`X` valid after edge n+1 (LOAD), `En` high for exactly `BURST` cycles (edges n+2..n+1+BURST), `Done` high for the cycle after edge n+2+BURST.
- Grant-to-grant minimum spacing: `BURST`+3 cycles (LOAD + RUN + FINISH + IDLE).
- Abort: `Req` low sampled at edge k in RUN → `En`=0 and FINISH from edge k+1; `Result` captured at edge k+2.
- `Done` never asserts in two consecutive cycles.
- Fairness: with all four requesting continuously, grant order 0,1,2,3,0,…

## Structure
- Shared package `fsm_cnt_pkg`: state encoding constants (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, FINISH=2'd3), `NREQ`, mode width 2.
- Sub-module `rr_pick`: combinational round-robin picker (inputs `Req`, `last`; outputs one-hot winner, index, valid). Scheduler instantiates it once; counter FSM instantiated outside, not inside this block.
- Two-always style: registered state/datapath plus combinational next-state.

## Test plan
- Reset then `Req`=4'b0001, `Mode[1:0]`=2: `Gnt`=0001 one cycle later, `X`=2, `En` high 4 cycles, `Done`=1 with `Abort`=0, `Result` equals counter's `Cuenta`.
- `Req`=4'b1111 held: grants 0,1,2,3,0 in order, each spaced 7 cycles (`BURST`=4).
- `last`=1, `Req`=4'b0011: requester 0 wins (wrap-around), then requester 1.
- Requester 2 drops `Req` after second RUN cycle: `En` low next cycle, `Done`=1, `Abort`=1, exactly 2 enabled cycles seen by counter.
- `Rst` asserted during RUN: next cycle `En`=0, `Gnt`=0, `X`=0, no `Done`; after release requester 0 again has priority.
- `Mode` changed during RUN: `X` unchanged until next grant.

Source files
------------

// File: rtl/fsm_cnt_pkg.sv
// Shared definitions for the counter scheduler: state encoding, widths, mode lookup.
package fsm_cnt_pkg;

   localparam int unsigned NReq   = 4;
   localparam int unsigned ModeW  = 2;
   localparam int unsigned IdxW   = 2;
   localparam int unsigned BurstW = 8;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLoad   = 2'd1,
      StRun    = 2'd2,
      StFinish = 2'd3
   } state_e;

   // Extract one requester's mode field from the packed mode bus.
   function automatic logic [ModeW-1:0] mode_of(input logic [NReq*ModeW-1:0] modes,
                                                input logic [IdxW-1:0]        idx);
      return modes[idx*ModeW +: ModeW];
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: search starts one past the last winner and wraps.
module rr_pick import fsm_cnt_pkg::*; #(
   parameter int unsigned NREQ = NReq
) (
   input  logic [NREQ-1:0] req,
   input  logic [IdxW-1:0] last,
   output logic [NREQ-1:0] onehot,
   output logic [IdxW-1:0] idx,
   output logic            valid
);

   logic [IdxW-1:0] cand;

   // First requesting index in the order last+1, last+2, ..., last (modulo NREQ).
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = last + IdxW'(k);
         if (!valid && req[cand]) begin
            valid        = 1'b1;
            idx          = cand;
            onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fsm_cnt_scheduler.sv
// Round-robin scheduler sharing one external counter FSM among four requesters.
// Each grant loads the winner's mode, enables the counter for BURST cycles (or
// until the winner drops its request) and returns the resulting count.
module fsm_cnt_scheduler import fsm_cnt_pkg::*; #(
   parameter int unsigned NREQ  = NReq,
   parameter int unsigned BURST = 4
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [NREQ-1:0]       Req,
   input  logic [NREQ*ModeW-1:0] Mode,
   input  logic [ModeW-1:0]      Cuenta,
   output logic [ModeW-1:0]      X,
   output logic                  En,
   output logic [NREQ-1:0]       Gnt,
   output logic                  Done,
   output logic                  Abort,
   output logic [ModeW-1:0]      Result
);

   localparam logic [BurstW-1:0] BurstInit = BurstW'(BURST);
   localparam logic [IdxW-1:0]   LastInit  = IdxW'(NREQ - 1);

   state_e              state_q, state_d;
   logic [ModeW-1:0]    x_q, x_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic [IdxW-1:0]     win_q, win_d;
   logic [IdxW-1:0]     last_q, last_d;
   logic [BurstW-1:0]   burst_q, burst_d;
   logic                abort_q, abort_d;
   logic [ModeW-1:0]    result_q, result_d;

   logic [NREQ-1:0]     pick_onehot;
   logic [IdxW-1:0]     pick_idx;
   logic                pick_valid;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req    (Req),
      .last   (last_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   // State and datapath registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= StIdle;
         x_q      <= '0;
         gnt_q    <= '0;
         win_q    <= '0;
         last_q   <= LastInit;
         burst_q  <= '0;
         abort_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         gnt_q    <= gnt_d;
         win_q    <= win_d;
         last_q   <= last_d;
         burst_q  <= burst_d;
         abort_q  <= abort_d;
         result_q <= result_d;
      end
   end

   // Next-state and datapath updates; everything holds unless a state says otherwise.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      gnt_d    = gnt_q;
      win_d    = win_q;
      last_d   = last_q;
      burst_d  = burst_q;
      abort_d  = abort_q;
      result_d = result_q;

      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               gnt_d   = pick_onehot;
               win_d   = pick_idx;
               x_d     = mode_of(Mode, pick_idx);
               abort_d = 1'b0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            // Counter sees the new mode for one cycle before it is enabled.
            burst_d = BurstInit;
            state_d = StRun;
         end
         StRun: begin
            burst_d = burst_q - 1'b1;
            if (!Req[win_q]) begin
               abort_d = 1'b1;
               state_d = StFinish;
            end else if (burst_q == BurstW'(1)) begin
               state_d = StFinish;
            end
         end
         StFinish: begin
            // Counter has absorbed its last enabled edge; freeze its value.
            result_d = Cuenta;
            last_d   = win_q;
            gnt_d    = '0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Moore outputs; Result follows the live count during the done cycle so it is
   // valid alongside Done, then holds the captured value.
   always_comb begin
      X      = x_q;
      Gnt    = gnt_q;
      En     = (state_q == StRun);
      Done   = (state_q == StFinish);
      Abort  = (state_q == StFinish) && abort_q;
      Result = (state_q == StFinish) ? Cuenta : result_q;
   end

endmodule

// File: tb/tb_fsm_cnt_scheduler.sv
// Self-checking bench for fsm_cnt_scheduler with a behavioural counter on Cuenta.
module tb_fsm_cnt_scheduler;

   localparam int unsigned BURST = 4;

   logic       Clk    = 1'b0;
   logic       Rst    = 1'b1;
   logic [3:0] req_v  = '0;
   logic [7:0] mode_v = '0;
   logic [1:0] cnt    = '0;
   logic [1:0] X;
   logic       En;
   logic [3:0] Gnt;
   logic       Done;
   logic       Abort;
   logic [1:0] Result;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   fsm_cnt_scheduler #(
      .NREQ  (4),
      .BURST (BURST)
   ) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .Req    (req_v),
      .Mode   (mode_v),
      .Cuenta (cnt),
      .X      (X),
      .En     (En),
      .Gnt    (Gnt),
      .Done   (Done),
      .Abort  (Abort),
      .Result (Result)
   );

   // Shared counter: mode 0 counts up, 1 down, 2 steps by two, 3 holds.
   always @(posedge Clk) begin
      if (Rst) cnt <= 2'd0;
      else if (En) begin
         case (X)
            2'd0:    cnt <= cnt + 2'd1;
            2'd1:    cnt <= cnt - 2'd1;
            2'd2:    cnt <= cnt + 2'd2;
            default: cnt <= cnt;
         endcase
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Count after n enabled cycles in mode x, from plain modular arithmetic.
   function automatic logic [1:0] exp_count(input logic [1:0] c0, input int n,
                                            input logic [1:0] x);
      int d;
      case (x)
         2'd0:    d = 1;
         2'd1:    d = 3;
         2'd2:    d = 2;
         default: d = 0;
      endcase
      return 2'((int'(c0) + n * d) % 4);
   endfunction

   function automatic int rr_model(input logic [3:0] r, input int last);
      for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction

   task automatic do_reset();
      req_v = '0;
      Rst   = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      check("reset X", X, 0);
      check("reset En", En, 0);
      check("reset Gnt", Gnt, 0);
      check("reset Done", Done, 0);
      check("reset Abort", Abort, 0);
      check("reset Result", Result, 0);
      Rst = 1'b0;
   endtask

   // One full grant from IDLE; drop_at > 0 releases Req after that many enabled cycles.
   task automatic txn(input logic [3:0] req, input logic [7:0] mode, input logic [3:0] exp_gnt,
                      input logic [1:0] exp_x, input int drop_at, input string tag);
      int         n_en    = 0;
      int         done_at = -1;
      int         stab    = 0;
      int         exp_n;
      logic [1:0] c0;
      logic [1:0] exp_res;
      req_v  = req;
      mode_v = mode;
      @(negedge Clk);
      check({tag, " load Gnt"}, Gnt, exp_gnt);
      check({tag, " load X"}, X, exp_x);
      check({tag, " load En"}, En, 0);
      c0     = cnt;
      mode_v = ~mode;
      for (int cyc = 0; cyc < int'(BURST) + 4; cyc++) begin
         @(negedge Clk);
         if (Gnt !== exp_gnt || X !== exp_x) stab++;
         if (Done) begin
            done_at = cyc;
            break;
         end
         if (En) begin
            n_en++;
            if (n_en == drop_at) req_v = req_v & ~exp_gnt;
         end
      end
      exp_n   = (drop_at > 0) ? drop_at : int'(BURST);
      exp_res = exp_count(c0, exp_n, exp_x);
      check({tag, " done cycle"}, done_at, exp_n);
      check({tag, " enabled cycles"}, n_en, exp_n);
      check({tag, " Abort"}, Abort, (drop_at > 0) ? 1 : 0);
      check({tag, " Result"}, Result, exp_res);
      check({tag, " Result vs Cuenta"}, Result, cnt);
      check({tag, " Gnt/X stable"}, stab, 0);
      req_v = req_v & ~exp_gnt;
      @(negedge Clk);
      check({tag, " post Done"}, Done, 0);
      check({tag, " post Gnt"}, Gnt, 0);
      check({tag, " post Result hold"}, Result, exp_res);
   endtask

   typedef struct {
      logic [3:0] req;
      logic [7:0] mode;
      logic [3:0] gnt;
      logic [1:0] x;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int         n_g;
      logic [3:0] g_seen[5];
      int         t_seen[5];
      logic [3:0] prev_g;
      int         dn;
      // random-phase state
      int         last_m, w, exp_w, n_en, drop_n, t_cyc, exp_n, n_grants;
      int         stab, dbl, spur, hang;
      logic       busy, dropped, prev_done, done_now;
      logic [1:0] c0, gx;
      logic [3:0] exp_g;

      tbl[0] = '{req: 4'b0001, mode: 8'h02, gnt: 4'b0001, x: 2'd2};
      tbl[1] = '{req: 4'b0110, mode: 8'h34, gnt: 4'b0010, x: 2'd1};
      tbl[2] = '{req: 4'b1000, mode: 8'hC0, gnt: 4'b1000, x: 2'd3};
      tbl[3] = '{req: 4'b1100, mode: 8'h60, gnt: 4'b0100, x: 2'd2};
      tbl[4] = '{req: 4'b1111, mode: 8'h1B, gnt: 4'b0001, x: 2'd3};
      tbl[5] = '{req: 4'b0100, mode: 8'h00, gnt: 4'b0100, x: 2'd0};

      // First grant after reset for several request patterns.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         txn(tbl[i].req, tbl[i].mode, tbl[i].gnt, tbl[i].x, -1, $sformatf("vec%0d", i));
      end

      // Fairness: all four requesting continuously.
      do_reset();
      req_v  = 4'b1111;
      mode_v = 8'h00;
      n_g    = 0;
      prev_g = '0;
      for (int c = 0; c < 5 * (int'(BURST) + 3) + 10 && n_g < 5; c++) begin
         @(negedge Clk);
         if (prev_g == 4'b0 && Gnt != 4'b0) begin
            g_seen[n_g] = Gnt;
            t_seen[n_g] = c;
            n_g++;
         end
         prev_g = Gnt;
      end
      for (int k = 0; k < 5; k++) begin
         check($sformatf("fair grant %0d", k), (k < n_g) ? g_seen[k] : 4'b0, 4'b1 << (k % 4));
         if (k > 0)
            check($sformatf("fair spacing %0d", k), (k < n_g) ? t_seen[k] - t_seen[k-1] : 0,
                  BURST + 3);
      end

      // Wrap-around: last winner 1, then 0 and 1 both request.
      do_reset();
      txn(4'b0010, 8'h04, 4'b0010, 2'd1, -1, "wrap a");
      txn(4'b0011, 8'h0D, 4'b0001, 2'd1, -1, "wrap b");
      txn(4'b0010, 8'h0C, 4'b0010, 2'd3, -1, "wrap c");

      // Abort: requester 2 drops after the second enabled cycle.
      do_reset();
      txn(4'b0100, 8'h10, 4'b0100, 2'd1, 2, "abort");

      // Reset in the middle of a burst.
      do_reset();
      txn(4'b0001, 8'h00, 4'b0001, 2'd0, -1, "pre rst");
      req_v  = 4'b0100;
      mode_v = 8'h20;
      @(negedge Clk);
      check("rst load Gnt", Gnt, 4'b0100);
      @(negedge Clk);
      @(negedge Clk);
      check("rst run En", En, 1);
      Rst   = 1'b1;
      req_v = '0;
      @(negedge Clk);
      check("rst mid En", En, 0);
      check("rst mid Gnt", Gnt, 0);
      check("rst mid X", X, 0);
      check("rst mid Done", Done, 0);
      check("rst mid Result", Result, 0);
      Rst = 1'b0;
      dn  = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         if (Done) dn++;
      end
      check("rst no Done", dn, 0);
      txn(4'b0101, 8'h11, 4'b0001, 2'd1, -1, "rst prio");

      // Randomized traffic against a transaction-level model.
      do_reset();
      last_m = 3; busy = 1'b0; prev_done = 1'b0; n_grants = 0;
      stab = 0; dbl = 0; spur = 0; hang = 0;
      w = 0; n_en = 0; drop_n = 0; t_cyc = 0; dropped = 1'b0; c0 = '0; gx = '0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge Clk);
         done_now = 1'b0;
         if (!busy) begin
            if (Gnt != 4'b0) begin
               exp_w = rr_model(req_v, last_m);
               exp_g = (exp_w >= 0) ? (4'b1 << exp_w) : 4'b0;
               check("rnd Gnt", Gnt, exp_g);
               w  = (exp_w >= 0) ? exp_w : 0;
               gx = mode_v[2*w +: 2];
               check("rnd X", X, gx);
               busy = 1'b1; c0 = cnt; n_en = 0; dropped = 1'b0; t_cyc = 0;
               n_grants++;
            end else if (Done) spur++;
         end else begin
            t_cyc++;
            if (Gnt !== (4'b1 << w) || X !== gx) stab++;
            if (En) n_en++;
            if (Done) begin
               exp_n = dropped ? drop_n : int'(BURST);
               check("rnd enabled cycles", n_en, exp_n);
               check("rnd Abort", Abort, dropped);
               check("rnd Result", Result, exp_count(c0, exp_n, gx));
               check("rnd latency", t_cyc, exp_n + 1);
               last_m   = w;
               busy     = 1'b0;
               req_v[w] = 1'b0;
               done_now = 1'b1;
            end else if (t_cyc > int'(BURST) + 5) begin
               hang++;
               busy = 1'b0;
            end
         end
         if (Done && prev_done) dbl++;
         prev_done = Done;
         mode_v = 8'($urandom);
         for (int i = 0; i < 4; i++) begin
            if (busy && i == w) begin
               if (En && !dropped && n_en < int'(BURST) && $urandom_range(0, 7) == 0) begin
                  req_v[i] = 1'b0;
                  dropped  = 1'b1;
                  drop_n   = n_en;
               end
            end else if (!req_v[i] && !(done_now && i == w) && $urandom_range(0, 3) == 0) begin
               req_v[i] = 1'b1;
            end
         end
      end
      check("rnd grant count ok", n_grants >= 50, 1);
      check("rnd Gnt/X stable", stab, 0);
      check("rnd Done back-to-back", dbl, 0);
      check("rnd spurious Done", spur, 0);
      check("rnd missing Done", hang, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
